// File: rtl/dds_pkg.sv
// Shared definitions for the DDS polynomial coefficient bank.
// Holds default geometry, coefficient slice indices and the bank-index type.
// Pure definitions: no logic, no latency, no flow control.
package dds_pkg;

  // Default geometry for one coefficient bank.
  localparam int DDS_DATA_WIDTH = 32;
  localparam int DDS_ADDR_WIDTH = 5;
  localparam int DDS_NUM_COEF   = 3;

  // Coefficient slice indices: Ak lives in rd_data slice k and is written with wr_sel == COEF_Ak.
  localparam logic [1:0] COEF_A0 = 2'd0;
  localparam logic [1:0] COEF_A1 = 2'd1;
  localparam logic [1:0] COEF_A2 = 2'd2;
  localparam logic [1:0] COEF_A3 = 2'd3;

  // Which of the two physical banks is meant.
  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  // The bank that is not b; used for shadow selection and swapping.
  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

  // Write-select code that addresses coefficient slot k.
  function automatic logic [1:0] coef_idx(input int k);
    case (k)
      0:       return COEF_A0;
      1:       return COEF_A1;
      2:       return COEF_A2;
      default: return COEF_A3;
    endcase
  endfunction

endpackage

// File: rtl/dds_coef_ram.sv
// One coefficient bank: NUM_COEF x DEPTH words, all coefficients of a segment read together.
// Read is combinational from the addressed row; a write lands at the rising edge.
// No flow control: one write per cycle accepted, out-of-range wr_sel silently dropped.
module dds_coef_ram
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH,
  parameter int NUM_COEF   = DDS_NUM_COEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [1:0]                     wr_sel,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [NUM_COEF*DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_COEF][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [NUM_COEF][DEPTH];

  // Next-state of the array: only the slot matching wr_sel changes; codes beyond NUM_COEF match nothing.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_COEF; k++) begin
      if (wr_en && (wr_sel == coef_idx(k))) begin
        mem_d[k][wr_addr] = wr_data;
      end
    end
  end

  // Storage; reset clears every word so an unloaded bank reads as zero coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem_q[k][a] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Gather the whole row: A0 in the low slice, Ak in slice k.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_COEF; k++) begin
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_addr];
    end
  end

endmodule

// File: rtl/dds_coef_bank.sv
// Double-buffered DDS coefficient store: reads from the active bank, writes to the shadow, swap on request.
// Read latency 2 cycles (request/bank capture, then row register); swap takes effect at the request edge.
// No backpressure: one request per cycle always accepted, rd_data holds between responses.
module dds_coef_bank
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH,
  parameter int NUM_COEF   = DDS_NUM_COEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           rd_valid,
  output logic [NUM_COEF*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [1:0]                     wr_sel,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           active_bank
);

  localparam int RD_WIDTH = NUM_COEF * DATA_WIDTH;

  // Stage 1: captured request and the bank that was active when it arrived.
  logic                  s1_vld_q,  s1_vld_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  bank_t                 s1_bank_q, s1_bank_d;

  // Stage 2: response register.
  logic                  rd_valid_q, rd_valid_d;
  logic [RD_WIDTH-1:0]   rd_data_q,  rd_data_d;

  // Bank control.
  bank_t                 active_bank_q, active_bank_d;
  logic                  swap_ack_q,    swap_ack_d;

  // Per-bank write enables and read rows.
  logic                  ram0_wr_en, ram1_wr_en;
  logic [RD_WIDTH-1:0]   ram0_rd_data, ram1_rd_data;
  logic [RD_WIDTH-1:0]   bank_rd_data;

  // Steer writes to the bank that is shadow before this edge; a same-cycle swap then exposes it.
  always_comb begin
    ram0_wr_en = wr_en && (active_bank_q == BANK1);
    ram1_wr_en = wr_en && (active_bank_q == BANK0);
  end

  dds_coef_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COEF   (NUM_COEF)
  ) u_ram0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram0_wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (s1_addr_q),
    .rd_data (ram0_rd_data)
  );

  dds_coef_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COEF   (NUM_COEF)
  ) u_ram1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram1_wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (s1_addr_q),
    .rd_data (ram1_rd_data)
  );

  // Read from the bank captured with the request, so a swap behind it cannot redirect it.
  always_comb begin
    bank_rd_data = (s1_bank_q == BANK1) ? ram1_rd_data : ram0_rd_data;
  end

  // Next-state for pipeline and bank control.
  always_comb begin
    s1_vld_d      = req_valid;
    s1_addr_d     = req_valid ? req_addr : s1_addr_q;
    s1_bank_d     = active_bank_q;
    rd_valid_d    = s1_vld_q;
    rd_data_d     = s1_vld_q ? bank_rd_data : rd_data_q;
    swap_ack_d    = swap_req;
    active_bank_d = swap_req ? other_bank(active_bank_q) : active_bank_q;
  end

  // State registers; reset drops any in-flight request and returns to bank 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_bank_q     <= BANK0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      swap_ack_q    <= 1'b0;
      active_bank_q <= BANK0;
    end else begin
      s1_vld_q      <= s1_vld_d;
      s1_addr_q     <= s1_addr_d;
      s1_bank_q     <= s1_bank_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      swap_ack_q    <= swap_ack_d;
      active_bank_q <= active_bank_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign swap_ack    = swap_ack_q;
  assign active_bank = active_bank_q;

endmodule

// File: tb/tb_dds_coef_bank.sv
// Directed bench for dds_coef_bank with a reference model of both banks.
// Expected rows are queued with their due cycle when a request is driven.
// A negedge monitor pops and compares responses, and checks idle/hold otherwise.
module tb_dds_coef_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 3;
  localparam int RW = NC * DW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          active_bank;

  dds_coef_bank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_COEF   (NC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .active_bank (active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [RW-1:0] dat;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DW-1:0] mdl [2][NC][32];
  logic          act;
  logic [RW-1:0] last_dat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mdl_rd(input logic b, input logic [AW-1:0] a);
    return {mdl[b][2][a], mdl[b][1][a], mdl[b][0][a]};
  endfunction

  function automatic logic [DW-1:0] pat(input int k, input int a);
    return (32'(k) * 32'h01000193) ^ (32'(a) * 32'h9e3779b9) ^ 32'h5a5a0000;
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < NC; k++)
        for (int a = 0; a < 32; a++)
          mdl[b][k][a] = '0;
    act      = 1'b0;
    last_dat = '0;
  endtask

  // One clock cycle of stimulus; model is updated as the DUT should be at the coming edge.
  task automatic step(input logic rv, input logic [AW-1:0] ra, input logic we,
                      input logic [1:0] ws, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic sw);
    exp_t e;
    req_valid = rv;
    req_addr  = ra;
    wr_en     = we;
    wr_sel    = ws;
    wr_addr   = wa;
    wr_data   = wd;
    swap_req  = sw;
    if (rv) begin
      e.due = cyc + 2;
      e.dat = mdl_rd(act, ra);
      sb.push_back(e);
    end
    if (we && (int'(ws) < NC)) mdl[~act][ws][wa] = wd;
    if (sw) act = ~act;
    @(negedge clk);
    chk("active_bank", 96'(active_bank), 96'(act));
    chk("swap_ack", 96'(swap_ack), 96'(sw));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic req(input int a);
    step(1'b1, 5'(a), 1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input int k, input int a, input logic [DW-1:0] d);
    step(1'b0, 5'd0, 1'b1, 2'(k), 5'(a), d, 1'b0);
  endtask

  task automatic swap();
    step(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 32'd0, 1'b1);
  endtask

  // Response monitor: a response must appear exactly on its due cycle, otherwise outputs idle and hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rd_valid", 96'(rd_valid), 96'd1);
        chk("rd_data", rd_data, e.dat);
        last_dat = e.dat;
      end else begin
        chk("rd_idle_valid", 96'(rd_valid), 96'd0);
        chk("rd_hold_data", rd_data, last_dat);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    wr_en     = 1'b0;
    wr_sel    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    swap_req  = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", 96'(rd_valid), 96'd0);
    chk("rst_rd_data", rd_data, 96'd0);
    chk("rst_swap_ack", 96'(swap_ack), 96'd0);
    chk("rst_active_bank", 96'(active_bank), 96'd0);
    rst_n = 1'b1;

    // Load A0..A2 of segment 3 into the shadow bank; before the swap the active bank still reads zero.
    wr(0, 3, 32'h03c00596);
    wr(1, 3, 32'h0b56f99a);
    wr(2, 3, 32'h127e5e56);
    req(3);
    idle(3);
    swap();
    idle(1);
    req(3);
    idle(3);

    // Fill bank 0 (now shadow) with a pattern, swap, then sweep every address back-to-back with wrap.
    for (int a = 0; a < 32; a++)
      for (int k = 0; k < NC; k++)
        wr(k, a, pat(k, a));
    swap();
    for (int a = 0; a < 32; a++) req(a);
    req(0);
    idle(3);

    // A request already captured before a swap still completes from its own bank.
    req(3);
    swap();
    req(3);
    idle(3);

    // Write into the shadow together with a swap; the next read sees it in the new active bank.
    step(1'b0, 5'd0, 1'b1, 2'd0, 5'd7, 32'hfc042cf0, 1'b1);
    req(7);
    idle(2);

    // Reads of addr 7 while writing addr 7 of the shadow; wr_sel=3 must be dropped.
    step(1'b1, 5'd7, 1'b1, 2'd3, 5'd7, 32'hdeadbeef, 1'b0);
    step(1'b1, 5'd7, 1'b1, 2'd1, 5'd7, 32'h12345678, 1'b0);
    swap();
    req(7);
    idle(3);

    // swap_req held high swaps and acknowledges every cycle.
    swap();
    swap();
    swap();
    swap();
    idle(1);

    // Reset with a response on the output and another request in stage 1.
    req(5);
    req(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", 96'(rd_valid), 96'd0);
    chk("midrst_rd_data", rd_data, 96'd0);
    chk("midrst_active_bank", 96'(active_bank), 96'd0);
    chk("midrst_swap_ack", 96'(swap_ack), 96'd0);
    req_valid = 1'b0;
    wr_en     = 1'b0;
    swap_req  = 1'b0;
    sb.delete();
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    req(3);
    idle(3);

    chk("scoreboard_drained", 96'(sb.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
